// File: rtl/round_robin_select_arbiter.sv
// 8-requester round-robin arbiter driving the select of a downstream 8:1 mux.
// The owner keeps SELECT until DONE, request withdrawal, or MAX_HOLD cycles elapse.
module round_robin_select_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] REQ,
    input  logic       DONE,
    output logic [2:0] SELECT,
    output logic [7:0] GRANT,
    output logic       VALID,
    output logic       TIMEOUT
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q;
    logic [2:0]      ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      select_q;
    logic [7:0]      grant_q;
    logic            valid_q;
    logic            timeout_q;

    logic [2:0]      winner;
    logic [2:0]      idx;
    logic            withdrawn;
    logic            hold_expired;
    logic            release_now;

    // Scan from lowest priority up so the last hit is the one closest to ptr_q.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int unsigned k = 8; k > 0; k--) begin
            idx = ptr_q + 3'(k - 1);
            if (REQ[idx]) begin
                winner = idx;
            end
        end
    end

    assign withdrawn    = ~REQ[select_q];
    assign hold_expired = (cnt_q == CW'(MAX_HOLD - 1));
    assign release_now  = DONE | withdrawn | hold_expired;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            select_q  <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|REQ) begin
                        select_q <= winner;
                        grant_q  <= 8'b1 << winner;
                        valid_q  <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        valid_q   <= 1'b0;
                        grant_q   <= '0;
                        ptr_q     <= select_q + 3'd1;
                        // DONE or withdrawal coinciding with expiry is a normal release.
                        timeout_q <= hold_expired & ~DONE & ~withdrawn;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SELECT  = select_q;
    assign GRANT   = grant_q;
    assign VALID   = valid_q;
    assign TIMEOUT = timeout_q;

endmodule
